// File: rtl/fetch_ctrl.sv
// fetch_ctrl: program-counter sequencer and single-outstanding instruction
// fetch handshake. Holds each fetched word until the downstream stage takes
// it, then chooses the next PC by priority trap > jal > jalr > branch > pc+4.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        trap_en,
    input  logic [31:0] trap_vec,
    input  logic        jmp_en,
    input  logic        jmpr_en,
    input  logic        jmpb_en,
    input  logic [31:0] jmp_to,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_err,
    output logic        misalign
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DELIV = 2'd3
    } state_t;

    // Last wait-counter value before the response is declared lost.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_r;
    logic [31:0] pc_r;
    logic [7:0]  cnt_r;
    logic        kill_r;
    logic [31:0] tgt_s;
    logic        wait_done_s;

    // Word-align an address by clearing its two low bits.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // True when an address is not on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    // The fetch address is the PC register itself, so it is stable in REQ.
    assign imem_addr = pc_r;

    // Retire-time next-PC selection: jal, then jalr, then branch, else pc+4.
    always_comb begin
        tgt_s = inst_pc + 32'd4;
        if (jmp_en) begin
            tgt_s = inst_pc + jmp_to;
        end else if (jmpr_en) begin
            tgt_s = jmp_to;
        end else if (jmpb_en) begin
            tgt_s = inst_pc + jmp_to;
        end else begin
            tgt_s = inst_pc + 32'd4;
        end
    end

    // The outstanding fetch ends this cycle, either by data or by timeout.
    always_comb begin
        if (imem_rvalid || (cnt_r == TMO_LAST)) begin
            wait_done_s = 1'b1;
        end else begin
            wait_done_s = 1'b0;
        end
    end

    // Fetch FSM with registered handshake, delivery and pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            pc_r       <= RESET_PC;
            cnt_r      <= 8'd0;
            kill_r     <= 1'b0;
            imem_req   <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= 32'd0;
            inst_pc    <= 32'd0;
            fetch_err  <= 1'b0;
            misalign   <= 1'b0;
        end else begin
            fetch_err <= 1'b0;
            misalign  <= 1'b0;
            if (trap_en) begin
                pc_r       <= align_word(trap_vec);
                misalign   <= is_misaligned(trap_vec);
                inst_valid <= 1'b0;
                case (state_r)
                    S_REQ: begin
                        if (imem_gnt) begin
                            // Request already accepted: drain its response.
                            state_r  <= S_WAIT;
                            kill_r   <= 1'b1;
                            cnt_r    <= 8'd0;
                            imem_req <= 1'b0;
                        end else begin
                            state_r  <= S_REQ;
                            imem_req <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (wait_done_s) begin
                            // The stale response ends now; nothing left to drain.
                            state_r  <= S_REQ;
                            kill_r   <= 1'b0;
                            imem_req <= 1'b1;
                        end else begin
                            kill_r <= 1'b1;
                            cnt_r  <= cnt_r + 8'd1;
                        end
                    end
                    default: begin
                        state_r  <= S_REQ;
                        imem_req <= 1'b1;
                    end
                endcase
            end else begin
                case (state_r)
                    S_IDLE: begin
                        state_r  <= S_REQ;
                        imem_req <= 1'b1;
                    end
                    S_REQ: begin
                        if (imem_gnt) begin
                            state_r  <= S_WAIT;
                            cnt_r    <= 8'd0;
                            imem_req <= 1'b0;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rvalid) begin
                            kill_r <= 1'b0;
                            if (kill_r) begin
                                state_r  <= S_REQ;
                                imem_req <= 1'b1;
                            end else begin
                                state_r    <= S_DELIV;
                                inst       <= imem_rdata;
                                inst_pc    <= pc_r;
                                inst_valid <= 1'b1;
                            end
                        end else if (cnt_r == TMO_LAST) begin
                            // Lost response: retry the same PC; silent if killed.
                            kill_r    <= 1'b0;
                            fetch_err <= ~kill_r;
                            state_r   <= S_REQ;
                            imem_req  <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + 8'd1;
                        end
                    end
                    S_DELIV: begin
                        if (!stall) begin
                            pc_r       <= align_word(tgt_s);
                            misalign   <= is_misaligned(tgt_s);
                            inst_valid <= 1'b0;
                            state_r    <= S_REQ;
                            imem_req   <= 1'b1;
                        end
                    end
                    default: begin
                        state_r  <= S_IDLE;
                        imem_req <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized bench for fetch_ctrl. The bench acts as the
// instruction memory and the downstream stage, keeps an event-level model of
// program flow (next fetch address, held instruction, live/killed fetch) and
// a scoreboard queue of expected deliveries that a monitor pops and compares.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TIMEOUT  = 16;
    localparam int          N_CYC    = 4000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, trap_en, jmp_en, jmpr_en, jmpb_en;
    logic [31:0] trap_vec, jmp_to;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        inst_valid, fetch_err, misalign;
    logic [31:0] inst, inst_pc;

    fetch_ctrl #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .trap_en(trap_en), .trap_vec(trap_vec),
        .jmp_en(jmp_en), .jmpr_en(jmpr_en), .jmpb_en(jmpb_en), .jmp_to(jmp_to),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .fetch_err(fetch_err), .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
    } deliv_t;

    deliv_t      exp_q[$];
    // Reference model state, valid after each rising edge.
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_held_pc = 32'd0;
    bit          m_held = 1'b0, m_out = 1'b0, m_killed = 1'b0;
    bit          m_err = 1'b0, m_mis = 1'b0;
    int          m_wcnt = 0, m_lat = 0, n_retired = 0;
    bit          done = 1'b0;

    int n_cmp = 0, n_bad = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compares DUT outputs against the model on every falling edge.
    initial begin : monitor
        deliv_t cur;
        bit     prev_valid;
        int     cyc;
        cur        = '{word: 32'd0, pc: 32'd0};
        prev_valid = 1'b0;
        cyc        = 0;
        forever begin
            @(negedge clk);
            if (done) begin
                n_cmp++;
                if (n_retired < 40) begin
                    n_bad++;
                    $display("FAIL progress: retired %0d expected at least 40", n_retired);
                end
                check32("undelivered", 32'(exp_q.size()), 32'd0);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
            if (rst) begin
                check1("rst_imem_req", imem_req, 1'b0);
                check32("rst_imem_addr", imem_addr, RESET_PC);
                check1("rst_inst_valid", inst_valid, 1'b0);
                check32("rst_inst", inst, 32'd0);
                check32("rst_inst_pc", inst_pc, 32'd0);
                check1("rst_fetch_err", fetch_err, 1'b0);
                check1("rst_misalign", misalign, 1'b0);
            end else begin
                cyc++;
                if (cyc == 1) check1("req_cycle1", imem_req, 1'b0);
                if (cyc == 2) check1("req_cycle2", imem_req, 1'b1);
                check1("inst_valid", inst_valid, m_held);
                check1("fetch_err", fetch_err, m_err);
                check1("misalign", misalign, m_mis);
                if (m_out) check1("req_while_outstanding", imem_req, 1'b0);
                if (imem_req) check32("imem_addr", imem_addr, m_pc);
                if (inst_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_inst: got pc %h with empty queue", inst_pc);
                    end else begin
                        cur = exp_q.pop_front();
                    end
                end
                if (inst_valid) begin
                    check32("inst", inst, cur.word);
                    check32("inst_pc", inst_pc, cur.pc);
                end
                prev_valid = inst_valid;
            end
        end
    end

    // Driver: memory slave plus downstream stage, and the reference model step.
    initial begin : driver
        logic [31:0] t, tgt;
        bit          calm, grant, retire, f_resp, f_tmo;
        rst = 1'b1;
        stall = 1'b0; trap_en = 1'b0; jmp_en = 1'b0; jmpr_en = 1'b0; jmpb_en = 1'b0;
        trap_vec = 32'd0; jmp_to = 32'd0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < N_CYC; c++) begin
            @(negedge clk);
            #1;
            calm = (c < 30);
            // Downstream and redirect stimulus.
            stall   = calm ? 1'b0 : ($urandom_range(0, 99) < 30);
            jmp_en  = calm ? 1'b0 : ($urandom_range(0, 99) < 20);
            jmpr_en = calm ? 1'b0 : ($urandom_range(0, 99) < 20);
            jmpb_en = calm ? 1'b0 : ($urandom_range(0, 99) < 20);
            t = 32'($urandom_range(0, 2047)) - 32'd1024;
            if ($urandom_range(0, 3) == 0) t = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            jmp_to = t;
            trap_en = calm ? 1'b0 : ($urandom_range(0, 99) < 3);
            t = $urandom;
            if ($urandom_range(0, 4) != 0) t[1:0] = 2'b00;
            trap_vec = t;
            // Memory slave: grant, response timing, spurious rvalid when idle.
            imem_gnt = calm ? 1'b1 : ($urandom_range(0, 99) < 70);
            if (m_out) imem_rvalid = (m_lat != 0) && (m_wcnt + 1 == m_lat);
            else       imem_rvalid = ($urandom_range(0, 99) < 10);
            imem_rdata = $urandom;

            // Model of what the coming rising edge does.
            retire = m_held && !stall;
            grant  = imem_req && imem_gnt;
            f_resp = m_out && imem_rvalid;
            f_tmo  = m_out && !imem_rvalid && (m_wcnt == TIMEOUT - 1);
            m_err  = 1'b0;
            m_mis  = 1'b0;
            if (m_out) m_wcnt++;
            if (f_resp || f_tmo) begin
                if (!m_killed && !trap_en) begin
                    if (f_resp) begin
                        m_held    = 1'b1;
                        m_held_pc = m_pc;
                        exp_q.push_back('{word: imem_rdata, pc: m_pc});
                    end else begin
                        m_err = 1'b1;
                    end
                end
                m_out    = 1'b0;
                m_killed = 1'b0;
            end else if (m_out && trap_en) begin
                m_killed = 1'b1;
            end
            if (trap_en) begin
                m_held = 1'b0;
                m_mis  = (trap_vec[1:0] != 2'b00);
                m_pc   = trap_vec & ~32'd3;
            end else if (retire) begin
                m_held = 1'b0;
                n_retired++;
                if (jmp_en)       tgt = m_held_pc + jmp_to;
                else if (jmpr_en) tgt = jmp_to;
                else if (jmpb_en) tgt = m_held_pc + jmp_to;
                else              tgt = m_held_pc + 32'd4;
                m_mis = (tgt[1:0] != 2'b00);
                m_pc  = tgt & ~32'd3;
            end
            if (grant) begin
                m_out    = 1'b1;
                m_wcnt   = 0;
                m_killed = trap_en;
                if (calm)                            m_lat = 1;
                else if ($urandom_range(0, 99) < 5)  m_lat = 0;
                else                                 m_lat = int'($urandom_range(1, 4));
            end
        end
        @(negedge clk);
        #1 done = 1'b1;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the program counter and the instruction-memory fetch handshake for the ECNURVCORE core.
- Keeps one fetch outstanding, holds the fetched instruction until the downstream stage consumes it, then computes the next PC.
- Next PC is chosen by priority: trap > jal > jalr > branch > sequential.
- Sits between the decode/execute stage and the instruction memory port; replaces free-running PC update with a stall- and latency-tolerant scheduler.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset release.
- TIMEOUT, 16, cycles to wait for imem_rvalid before declaring a fetch error (range 2..255).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  downstream not ready; holds inst_valid/inst/inst_pc.
- trap_en  in  1  trap request, accepted in any state.
- trap_vec  in  32  absolute trap target.
- jmp_en  in  1  jal: target = inst_pc + jmp_to.
- jmpr_en  in  1  jalr: target = jmp_to.
- jmpb_en  in  1  taken branch: target = inst_pc + jmp_to.
- jmp_to  in  32  offset or absolute target.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, word aligned.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  instruction available to decode.
- inst  out  32  instruction word.
- inst_pc  out  32  PC of inst.
- fetch_err  out  1  one-cycle pulse on response timeout.
- misalign  out  1  one-cycle pulse when a selected target has bits[1:0] != 0.

Behaviour:
- Reset (async, rst=1): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, fetch_err=0, misalign=0, timeout counter=0, kill=0.
- IDLE: next cycle goes to REQ. First imem_req asserts in the 2nd cycle after reset deassertion.
- REQ: imem_req=1, imem_addr=pc, both held stable until imem_gnt.
  - On gnt: go to WAIT, clear counter.
- WAIT: count cycles.
  - On imem_rvalid: latch inst=imem_rdata, inst_pc=pc, inst_valid=1, go to DELIV.
  - Response may arrive the cycle after gnt at the earliest (latency >=1).
  - If counter reaches TIMEOUT-1 without rvalid: pulse fetch_err, return to REQ with same pc.
- DELIV: inst_valid=1.
  - While stall=1, hold all outputs and ignore jmp_en/jmpr_en/jmpb_en.
  - When stall=0 the instruction retires. Redirect inputs are sampled in that cycle and pc is updated by priority: jmp_en, then jmpr_en, then jmpb_en, else inst_pc+4.
  - Then inst_valid=0 and go to REQ. Exactly one instruction is delivered per fetch.
- Trap (highest priority, any state except reset):
  - pc=trap_vec, inst_valid=0.
  - From IDLE, REQ or DELIV: go to REQ. In REQ this takes effect even in the gnt cycle; the granted response is then killed.
  - From WAIT, or from REQ on its gnt cycle: set kill=1 and stay in or enter WAIT. The next rvalid (or timeout) is discarded without delivery or fetch_err; kill clears and the state goes to REQ.
  - Trap in the same cycle as a retiring redirect: trap wins.
- Arithmetic: 32-bit add, wrap modulo 2^32, no overflow flag.
- Alignment: if the selected target has bits[1:0] != 0, pulse misalign the following cycle. pc stores the target with bits[1:0] forced to 0.
- imem_req never asserts in WAIT or DELIV: at most one outstanding fetch.
- imem_rvalid in IDLE, REQ or DELIV is ignored.

Test Plan:
- Reset release, RESET_PC=0, gnt and rvalid 1 cycle later, stall=0: imem_addr sequence 0x0, 0x4, 0x8; inst_pc matches each; first imem_req in cycle 2 after release.
- DELIV at inst_pc=0x100, stall=1 for 3 cycles with jmp_en=1, jmp_to=0x40 throughout, then stall=0: outputs constant during stall; next imem_addr=0x140.
- Retire at inst_pc=0x200 with jmp_en=0, jmpr_en=1, jmpb_en=1, jmp_to=0x1000: next imem_addr=0x1000 (jalr over branch). Repeat with jmpb_en only, jmp_to=0xFFFF_FFF0: next address 0x1F0.
- trap_en in WAIT at pc=0x300, trap_vec=0x80, rdata=0xDEADBEEF arrives 2 cycles later: no inst_valid for 0xDEADBEEF, no fetch_err; next imem_addr=0x80.
- gnt given, rvalid withheld, TIMEOUT=16: fetch_err pulses once in cycle 16 after gnt; imem_req re-asserts with the same address.
- Retire with jmpr_en=1, jmp_to=0x103: misalign pulses one cycle; imem_addr=0x100.
